// File: rtl/flt2int_param.sv
// flt2int_param: packed float to signed integer converter.
//
// Reads a packed float (1 sign, EXP_W exponent, MAN_W fraction bits) byte by
// byte from a byte-wide data memory, converts it to an INT_W-bit two's
// complement integer (truncate toward zero or round-to-nearest-even, with
// saturation), and writes the result back LSB first. The magnitude is shifted
// one bit per cycle, so latency depends on the exponent.
//
// Ports:
//   clk          - clock, rising edge
//   reset        - synchronous, active-high reset; aborts any operation
//   start        - request level; an operation begins on its falling edge
//   round_mode   - 0 truncate, 1 nearest-even; sampled with the start edge
//   mem_addr     - data memory byte address
//   mem_rd_data  - data memory read data (combinational w.r.t. mem_addr)
//   mem_wr_data  - data memory write data
//   mem_wr       - write strobe, byte written at the clk edge
//   busy         - high from the start falling edge until done
//   done         - single-cycle completion pulse
module flt2int_param #(
  parameter int EXP_W    = 5,
  parameter int MAN_W    = 10,
  parameter int INT_W    = 16,
  parameter int SRC_ADDR = 4,
  parameter int DST_ADDR = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       round_mode,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rd_data,
  output logic [7:0] mem_wr_data,
  output logic       mem_wr,
  output logic       busy,
  output logic       done
);

  localparam int FLT_W  = 1 + EXP_W + MAN_W;
  localparam int NB_IN  = FLT_W / 8;
  localparam int NB_OUT = INT_W / 8;
  localparam int BIAS   = (1 << (EXP_W - 1)) - 1;
  // Wide enough for the integer plus one bit, and for the full significand.
  localparam int MAG_W  = (INT_W + 1 > MAN_W + 1) ? (INT_W + 1) : (MAN_W + 1);

  localparam logic [INT_W-1:0] POS_MAX   = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] NEG_MAX   = {1'b1, {(INT_W-1){1'b0}}};
  localparam logic [MAG_W-1:0] MAG_LIMIT = {{(MAG_W-1){1'b0}}, 1'b1} << (INT_W - 1);
  localparam logic [7:0]       SRC8      = 8'(SRC_ADDR);
  localparam logic [7:0]       DST8      = 8'(DST_ADDR);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_UNPACK = 3'd2,
    S_SHIFT  = 3'd3,
    S_ROUND  = 3'd4,
    S_WR     = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  // Saturated value for the given sign.
  function automatic logic [INT_W-1:0] sat_value(input logic neg);
    return neg ? NEG_MAX : POS_MAX;
  endfunction

  // Byte idx of an integer value, LSB first.
  function automatic logic [7:0] get_byte(input logic [INT_W-1:0] v, input logic [2:0] idx);
    return 8'(v >> {idx, 3'b000});
  endfunction

  state_t             state_q, state_d;
  logic               start_q;
  logic               round_q, round_d;
  logic [FLT_W-1:0]   flt_q, flt_d;
  logic [2:0]         byte_cnt_q, byte_cnt_d;
  logic [MAG_W-1:0]   mag_q, mag_d;
  logic               guard_q, guard_d;
  logic               sticky_q, sticky_d;
  logic               shl_q, shl_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [INT_W-1:0]   result_q, result_d;
  logic [7:0]         mem_addr_q, mem_addr_d;
  logic [7:0]         mem_wr_data_q, mem_wr_data_d;
  logic               mem_wr_q, mem_wr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Decoded float fields and rounding helpers.
  logic               sgn_s;
  logic [EXP_W-1:0]   exp_s;
  logic [MAN_W-1:0]   frac_s;
  logic [MAN_W:0]     sig_s;
  logic signed [31:0] exp_unb_s;
  logic signed [31:0] shift_s;
  logic               inc_s;
  logic [MAG_W-1:0]   mag_rnd_s;

  assign mem_addr    = mem_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign mem_wr      = mem_wr_q;
  assign busy        = busy_q;
  assign done        = done_q;

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      start_q       <= 1'b0;
      round_q       <= 1'b0;
      flt_q         <= '0;
      byte_cnt_q    <= 3'd0;
      mag_q         <= '0;
      guard_q       <= 1'b0;
      sticky_q      <= 1'b0;
      shl_q         <= 1'b0;
      cnt_q         <= 32'd0;
      result_q      <= '0;
      mem_addr_q    <= 8'h00;
      mem_wr_data_q <= 8'h00;
      mem_wr_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_q       <= start;
      round_q       <= round_d;
      flt_q         <= flt_d;
      byte_cnt_q    <= byte_cnt_d;
      mag_q         <= mag_d;
      guard_q       <= guard_d;
      sticky_q      <= sticky_d;
      shl_q         <= shl_d;
      cnt_q         <= cnt_d;
      result_q      <= result_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      mem_wr_q      <= mem_wr_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // Next-state, datapath and next-output logic.
  always_comb begin
    state_d       = state_q;
    round_d       = round_q;
    flt_d         = flt_q;
    byte_cnt_d    = byte_cnt_q;
    mag_d         = mag_q;
    guard_d       = guard_q;
    sticky_d      = sticky_q;
    shl_d         = shl_q;
    cnt_d         = cnt_q;
    result_d      = result_q;
    mem_addr_d    = 8'h00;
    mem_wr_data_d = 8'h00;
    mem_wr_d      = 1'b0;
    busy_d        = busy_q;
    done_d        = 1'b0;

    sgn_s     = flt_q[FLT_W-1];
    exp_s     = flt_q[FLT_W-2 -: EXP_W];
    frac_s    = flt_q[MAN_W-1:0];
    sig_s     = {|exp_s, frac_s};
    exp_unb_s = $signed({{(32-EXP_W){1'b0}}, exp_s}) - BIAS;
    shift_s   = 32'sd0;
    inc_s     = round_q & guard_q & (sticky_q | mag_q[0]);
    mag_rnd_s = mag_q + {{(MAG_W-1){1'b0}}, inc_s};

    case (state_q)
      S_IDLE: begin
        // Falling edge of start; only seen here, so activity while busy is ignored.
        if (start_q && !start) begin
          state_d    = S_RD;
          round_d    = round_mode;
          busy_d     = 1'b1;
          byte_cnt_d = 3'd0;
          mem_addr_d = SRC8;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RD: begin
        flt_d[{byte_cnt_q, 3'b000} +: 8] = mem_rd_data;
        if (byte_cnt_q == 3'(NB_IN - 1)) begin
          state_d    = S_UNPACK;
          byte_cnt_d = 3'd0;
        end else begin
          byte_cnt_d = byte_cnt_q + 3'd1;
          mem_addr_d = SRC8 + {5'b00000, byte_cnt_q + 3'd1};
        end
      end

      S_UNPACK: begin
        mag_d      = '0;
        mag_d[MAN_W:0] = sig_s;
        guard_d    = 1'b0;
        sticky_d   = 1'b0;
        byte_cnt_d = 3'd0;
        if ((&exp_s) && (|frac_s)) begin
          // NaN converts to the positive maximum regardless of sign.
          result_d = POS_MAX;
        end else if ((&exp_s) || (exp_unb_s >= (INT_W - 1))) begin
          result_d = sat_value(sgn_s);
        end else if ((~|exp_s) || (exp_unb_s < -32'sd1)) begin
          // Zero, flushed denormals and anything below 0.5 give 0 in both modes.
          result_d = '0;
        end else begin
          result_d = result_q;
        end

        if ((&exp_s) || (~|exp_s) || (exp_unb_s >= (INT_W - 1)) || (exp_unb_s < -32'sd1)) begin
          state_d       = S_WR;
          mem_wr_d      = 1'b1;
          mem_addr_d    = DST8;
          mem_wr_data_d = get_byte(result_d, 3'd0);
        end else begin
          if (exp_unb_s > MAN_W) begin
            shl_d   = 1'b1;
            shift_s = exp_unb_s - MAN_W;
          end else begin
            shl_d   = 1'b0;
            shift_s = MAN_W - exp_unb_s;
          end
          cnt_d = shift_s;
          if (shift_s == 32'sd0) begin
            state_d = S_ROUND;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end

      S_SHIFT: begin
        if (shl_q) begin
          mag_d = mag_q << 1;
        end else begin
          // Right shift: dropped bit becomes guard, old guard folds into sticky.
          mag_d    = mag_q >> 1;
          guard_d  = mag_q[0];
          sticky_d = sticky_q | guard_q;
        end
        cnt_d = cnt_q - 32'd1;
        if (cnt_q == 32'd1) begin
          state_d = S_ROUND;
        end else begin
          state_d = S_SHIFT;
        end
      end

      S_ROUND: begin
        if (mag_rnd_s >= MAG_LIMIT) begin
          result_d = sat_value(sgn_s);
        end else if (sgn_s) begin
          result_d = ~mag_rnd_s[INT_W-1:0] + {{(INT_W-1){1'b0}}, 1'b1};
        end else begin
          result_d = mag_rnd_s[INT_W-1:0];
        end
        state_d       = S_WR;
        byte_cnt_d    = 3'd0;
        mem_wr_d      = 1'b1;
        mem_addr_d    = DST8;
        mem_wr_data_d = get_byte(result_d, 3'd0);
      end

      S_WR: begin
        if (byte_cnt_q == 3'(NB_OUT - 1)) begin
          state_d    = S_DONE;
          byte_cnt_d = 3'd0;
          done_d     = 1'b1;
          busy_d     = 1'b0;
        end else begin
          byte_cnt_d    = byte_cnt_q + 3'd1;
          mem_wr_d      = 1'b1;
          mem_addr_d    = DST8 + {5'b00000, byte_cnt_q + 3'd1};
          mem_wr_data_d = get_byte(result_q, byte_cnt_q + 3'd1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_flt2int_param.sv
module tb_flt2int_param;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  // Instance A: default half-precision configuration.
  logic        start_a, round_a, wr_a, busy_a, done_a;
  logic [7:0]  addr_a, rd_a, wd_a;
  logic [15:0] src_a;
  logic [15:0] res_a;
  int          wr_cnt_a = 0;
  int          bad_wr_a = 0;

  // Instance B: IEEE single precision to 32-bit integer.
  logic        start_b, round_b, wr_b, busy_b, done_b;
  logic [7:0]  addr_b, rd_b, wd_b;
  logic [31:0] src_b;
  logic [31:0] res_b;
  int          wr_cnt_b = 0;
  int          bad_wr_b = 0;

  int total = 0;
  int bad   = 0;

  flt2int_param dut_a (
    .clk(clk), .reset(reset), .start(start_a), .round_mode(round_a),
    .mem_addr(addr_a), .mem_rd_data(rd_a), .mem_wr_data(wd_a),
    .mem_wr(wr_a), .busy(busy_a), .done(done_a)
  );

  flt2int_param #(.EXP_W(8), .MAN_W(23), .INT_W(32), .SRC_ADDR(0), .DST_ADDR(8)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .round_mode(round_b),
    .mem_addr(addr_b), .mem_rd_data(rd_b), .mem_wr_data(wd_b),
    .mem_wr(wr_b), .busy(busy_b), .done(done_b)
  );

  always_comb begin
    case (addr_a)
      8'd4:    rd_a = src_a[7:0];
      8'd5:    rd_a = src_a[15:8];
      default: rd_a = 8'h00;
    endcase
  end

  always_comb begin
    case (addr_b)
      8'd0:    rd_b = src_b[7:0];
      8'd1:    rd_b = src_b[15:8];
      8'd2:    rd_b = src_b[23:16];
      8'd3:    rd_b = src_b[31:24];
      default: rd_b = 8'h00;
    endcase
  end

  always @(posedge clk) begin
    if (wr_a) begin
      wr_cnt_a <= wr_cnt_a + 1;
      case (addr_a)
        8'd6:    res_a[7:0]  <= wd_a;
        8'd7:    res_a[15:8] <= wd_a;
        default: bad_wr_a    <= bad_wr_a + 1;
      endcase
    end
  end

  always @(posedge clk) begin
    if (wr_b) begin
      wr_cnt_b <= wr_cnt_b + 1;
      case (addr_b)
        8'd8:    res_b[7:0]   <= wd_b;
        8'd9:    res_b[15:8]  <= wd_b;
        8'd10:   res_b[23:16] <= wd_b;
        8'd11:   res_b[31:24] <= wd_b;
        default: bad_wr_b     <= bad_wr_b + 1;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_a(input string tag, input logic [15:0] flt, input logic mode,
                       input logic [15:0] expv, input int exp_lat);
    int   cyc;
    int   w0;
    logic seen;
    src_a   = flt;
    round_a = mode;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    w0   = wr_cnt_a;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) round_a = ~mode;
      if (done_a) seen = 1'b1;
    end
    chk({tag, " done"}, {31'd0, seen}, 32'd1);
    chk({tag, " latency"}, cyc, exp_lat);
    chk({tag, " result"}, {16'd0, res_a}, {16'd0, expv});
    chk({tag, " writes"}, wr_cnt_a - w0, 32'd2);
    chk({tag, " busy at done"}, {31'd0, busy_a}, 32'd0);
    @(posedge clk); #1;
    chk({tag, " done pulse"}, {31'd0, done_a}, 32'd0);
  endtask

  task automatic run_b(input string tag, input logic [31:0] flt, input logic mode,
                       input logic [31:0] expv, input int exp_lat);
    int   cyc;
    int   w0;
    logic seen;
    src_b   = flt;
    round_b = mode;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    w0   = wr_cnt_b;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (done_b) seen = 1'b1;
    end
    chk({tag, " done"}, {31'd0, seen}, 32'd1);
    chk({tag, " latency"}, cyc, exp_lat);
    chk({tag, " result"}, res_b, expv);
    chk({tag, " writes"}, wr_cnt_b - w0, 32'd4);
  endtask

  initial begin
    int w0;
    int seen_done;
    reset   = 1'b1;
    start_a = 1'b0; round_a = 1'b0; src_a = 16'h0000;
    start_b = 1'b0; round_b = 1'b0; src_b = 32'h0000_0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy",  {31'd0, busy_a}, 32'd0);
    chk("rst done",  {31'd0, done_a}, 32'd0);
    chk("rst wr",    {31'd0, wr_a},   32'd0);
    chk("rst addr",  {24'd0, addr_a}, 32'd0);
    chk("rst wdata", {24'd0, wd_a},   32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_a("one m0",     16'h3C00, 1'b0, 16'h0001, 17);
    run_a("1024 m1",    16'h6400, 1'b1, 16'h0400, 7);
    run_a("one m1",     16'h3C00, 1'b1, 16'h0001, 17);
    run_a("1p5 m1",     16'h3E00, 1'b1, 16'h0002, 17);
    run_a("1p5 m0",     16'h3E00, 1'b0, 16'h0001, 17);
    run_a("2p5 m1",     16'h4100, 1'b1, 16'h0002, 16);
    run_a("0p5 m1",     16'h3800, 1'b1, 16'h0000, 18);
    run_a("0p75 m1",    16'h3A00, 1'b1, 16'h0001, 18);
    run_a("0p25 m1",    16'h3400, 1'b1, 16'h0000, 6);
    run_a("m5 m0",      16'hC500, 1'b0, 16'hFFFB, 15);
    run_a("m0 m1",      16'h8000, 1'b1, 16'h0000, 6);
    run_a("m2p5 m1",    16'hC100, 1'b1, 16'hFFFE, 16);
    run_a("denorm m1",  16'h0001, 1'b1, 16'h0000, 6);
    run_a("32768 m0",   16'h7800, 1'b0, 16'h7FFF, 6);
    run_a("m32768 m1",  16'hF800, 1'b1, 16'h8000, 6);
    run_a("65504 m1",   16'h7BFF, 1'b1, 16'h7FFF, 6);
    run_a("pinf m0",    16'h7C00, 1'b0, 16'h7FFF, 6);
    run_a("ninf m1",    16'hFC00, 1'b1, 16'h8000, 6);
    run_a("nan m0",     16'h7E00, 1'b0, 16'h7FFF, 6);
    run_a("32752 m1",   16'h77FF, 1'b1, 16'h7FF0, 11);
    run_a("m32752 m1",  16'hF7FF, 1'b1, 16'h8010, 11);
    run_a("m32768 m0",  16'hF800, 1'b0, 16'h8000, 6);

    // Abort in SHIFT: reset for one cycle, then nothing more may happen.
    src_a   = 16'h3C00;
    round_a = 1'b0;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("abort busy before", {31'd0, busy_a}, 32'd1);
    w0 = wr_cnt_a;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort busy", {31'd0, busy_a}, 32'd0);
    chk("abort done", {31'd0, done_a}, 32'd0);
    chk("abort wr",   {31'd0, wr_a},   32'd0);
    seen_done = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done_a) seen_done++;
    end
    chk("abort no done",   seen_done, 32'd0);
    chk("abort no writes", wr_cnt_a - w0, 32'd0);
    run_a("after abort m0", 16'hC500, 1'b0, 16'hFFFB, 15);

    run_b("sp 1p5 m1",   32'h3FC0_0000, 1'b1, 32'h0000_0002, 34);
    run_b("sp m2e31 m0", 32'hCF00_0000, 1'b0, 32'h8000_0000, 10);

    chk("stray writes a", bad_wr_a, 32'd0);
    chk("stray writes b", bad_wr_b, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flt2int_param.md
Name: flt2int_param

Overview:
- Synthesizable, parametrised float-to-signed-integer converter; next generation of the program-2 flt2int block.
- Reads a packed float (1 sign, EXP_W exponent, MAN_W mantissa) from data memory.
- Converts it with a selectable rounding mode and saturation, then writes the INT_W-bit two's-complement result back to data memory.
- Sits between the test-bench start/done handshake and the shared byte-wide data_mem.
- Shifting is iterative (one bit per cycle), so latency depends on the exponent.

Parameters:
- EXP_W, 5: exponent field width. Bias = 2^(EXP_W-1)-1.
- MAN_W, 10: stored mantissa (fraction) width.
- INT_W, 16: output integer width. Multiple of 8, 8..32.
- SRC_ADDR, 4: byte address of the float's least-significant byte.
- DST_ADDR, 6: byte address of the result's least-significant byte.
- Constraint: 1+EXP_W+MAN_W is a multiple of 8, at most 32. NB_IN = (1+EXP_W+MAN_W)/8; NB_OUT = INT_W/8.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: reset, synchronous, active-high.
- start, input, 1: request level from bench. Operation begins on its falling edge.
- round_mode, input, 1: 0 = truncate toward zero; 1 = round-to-nearest, ties-to-even. Sampled on the falling edge of start.
- mem_addr, output, 8: data memory byte address.
- mem_rd_data, input, 8: data memory read data, asynchronous (valid the same cycle as mem_addr).
- mem_wr_data, output, 8: data memory write data.
- mem_wr, output, 1: write strobe; byte written at the clk edge.
- busy, output, 1: high from the falling edge of start until done.
- done, output, 1: single-cycle acknowledge pulse.

Behaviour:
- Reset (synchronous): FSM to IDLE; busy, done and mem_wr = 0; mem_addr and mem_wr_data = 0; start history register = 0. Reset mid-operation aborts immediately: no further writes, no done pulse.
- Start detect: start_q registers start. Trigger = start_q & ~start, acted on only in IDLE. start activity while busy is ignored.
- FSM: IDLE -> RD -> UNPACK -> SHIFT -> ROUND -> WR -> DONE -> IDLE.
- RD, NB_IN cycles: mem_addr = SRC_ADDR+k, k = 0..NB_IN-1 (little-endian). Each byte is latched into the float register at the end of its cycle.
- UNPACK, 1 cycle:
  - s = sign, e = exponent, f = fraction, E = e - bias (signed).
  - sig = {|e, f}; e == 0 flushes to zero, no denormals.
  - Special results set a bypass flag and skip SHIFT and ROUND:
    - e all ones and f != 0 (NaN): result 2^(INT_W-1)-1.
    - e all ones and f == 0 (Inf), or E >= INT_W-1: result = s ? -2^(INT_W-1) : 2^(INT_W-1)-1. This covers exact -2^(INT_W-1) correctly.
    - E < -1: magnitude < 0.5, result 0 in both modes. Guard/sticky are not needed.
  - Otherwise shift count n = |E - MAN_W|, direction left if E > MAN_W, right if E < MAN_W.
- SHIFT: n cycles, one bit per cycle, decrementing counter; n = 0 skips directly to ROUND.
  - On right shifts, the bit shifted out moves to guard, and the previous guard ORs into sticky.
  - The magnitude register is INT_W+1 bits wide.
- ROUND, 1 cycle:
  - If round_mode = 1 and guard & (sticky | mag[0]): mag = mag + 1.
  - If mag >= 2^(INT_W-1): saturate exactly as in UNPACK.
  - Otherwise result = s ? -mag : mag.
  - -0 produces 0.
- WR, NB_OUT cycles: mem_wr = 1, mem_addr = DST_ADDR+k, mem_wr_data = result[8k+7:8k], LSB first.
- DONE: done = 1 for exactly one cycle, busy drops the same cycle, return to IDLE. A new falling edge of start in this cycle is not captured.
- Latency, falling edge to done (cycles): 1 + NB_IN + 1 + n + 1 + NB_OUT. The bypass path omits the n + 1 term.
- Only bytes DST_ADDR..DST_ADDR+NB_OUT-1 are ever written; source bytes are never modified.

Test Plan (defaults; float stored at mem[5:4], result read from mem[7:6]):
- 0x3C00 (1.0), either mode -> 0x0001; done after 1+2+1+10+1+2 = 17 cycles; exactly 2 writes observed.
- 0x3E00 (1.5): mode 0 -> 0x0001; mode 1 -> 0x0002. 0x4100 (2.5): mode 1 -> 0x0002 (tie to even). 0x3800 (0.5): mode 1 -> 0x0000.
- 0xC500 (-5.0) -> 0xFFFB. 0x8000 (-0) -> 0x0000. 0x0001 (denormal) -> 0x0000.
- Saturation, both modes:
  - 0x7800 (32768) -> 0x7FFF.
  - 0xF800 (-32768) -> 0x8000.
  - 0x7BFF (65504) -> 0x7FFF.
  - 0x7C00 (+Inf) -> 0x7FFF; 0xFC00 -> 0x8000; 0x7E00 (NaN) -> 0x7FFF.
  - Bypass latency is 6 cycles.
- Rounding overflow: 0x77FF (32752) mode 1 -> 0x7FF0. 0xF7FF -> 0x8010.
- Reset asserted during SHIFT of 0x3C00 -> no mem_wr, no done, busy = 0 the next cycle. A following normal request converts correctly.
- Parameter sweep: EXP_W = 8, MAN_W = 23, INT_W = 32 (IEEE single). 0x3FC00000 (1.5), mode 1 -> 0x00000002 across 4 result bytes. 0xCF000000 (-2^31) -> 0x80000000.
